alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_muldiv_seq.sv | 197 +++++++++++++++++++
 rtl/alu_muldiv.sv | 61 ++++++
 tb/tb_alu_muldiv.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_muldiv block: 4-bit operation codes and the
// multi-cycle engine state type.
package alu_pkg;

  // Single-cycle operations
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;

  // Multi-cycle operations
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  // Codes 10xx launch the multiply/divide engine
  function automatic logic is_multi(input logic [3:0] code);
    return code[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle multiply/divide engine: FSM, iteration counter, shift-add
// multiplier and restoring divider, plus the architectural HI/LO registers.
// Divide support is compiled in only when ALU_MULDIV_DIV_EN is defined;
// otherwise divide codes complete immediately without touching HI/LO/div0.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic             neg_q;    // negate product or quotient in FIX

  logic             accept;
  logic             is_mul;
  logic             signed_op;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept    = start && (state == S_IDLE) && is_multi(control);
  assign is_mul    = (control == OP_MULT) || (control == OP_MULTU);
  assign signed_op = (control == OP_MULT) || (control == OP_DIV);
  assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

  // One shift-add multiply step on the {acc_hi, acc_lo} pair
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path; a missing
    // default would infer a latch.
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
  end

  assign prod_mag = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod_mag : prod_mag;

`ifdef ALU_MULDIV_DIV_EN
  logic             op_div;   // current operation is a divide
  logic             neg_r;    // negate remainder in FIX
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

  // One restoring-division step: shift in a dividend bit, trial subtract
  always_comb begin
    rem_sh    = {acc_hi, acc_lo[WIDTH-1]};
    rem_diff  = rem_sh - {1'b0, opnd};
    div_hi_nx = rem_sh[WIDTH-1:0];
    div_lo_nx = {acc_lo[WIDTH-2:0], 1'b0};
    if (!rem_diff[WIDTH]) begin
      div_hi_nx = rem_diff[WIDTH-1:0];
      div_lo_nx = {acc_lo[WIDTH-2:0], 1'b1};
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) state_nx = S_MUL;
`ifdef ALU_MULDIV_DIV_EN
          else if (b == '0) state_nx = S_FIX;
          else              state_nx = S_DIV;
`endif
        end
      end
      S_MUL, S_DIV: if (cnt == LAST) state_nx = S_FIX;
      S_FIX:        state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Datapath, counter, HI/LO and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      div0   <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      op_div <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (is_mul) begin
              acc_hi <= '0;
              acc_lo <= b_mag;
              opnd   <= a_mag;
              neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              div0   <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
              op_div <= 1'b0;
              neg_r  <= 1'b0;
            end else if (b == '0) begin
              // Divide by zero: preload the final answer, FIX passes it through
              acc_hi <= a;
              acc_lo <= '1;
              neg_q  <= 1'b0;
              neg_r  <= 1'b0;
              op_div <= 1'b1;
              div0   <= 1'b1;
            end else begin
              acc_hi <= '0;
              acc_lo <= a_mag;
              opnd   <= b_mag;
              neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r  <= signed_op && a[WIDTH-1];
              op_div <= 1'b1;
              div0   <= 1'b0;
            end
`else
            end else begin
              // No divider built: acknowledge immediately, state untouched
              done <= 1'b1;
            end
`endif
          end
        end
        S_MUL: begin
          acc_hi <= mul_hi_nx;
          acc_lo <= mul_lo_nx;
          cnt    <= cnt + 1'b1;
        end
`ifdef ALU_MULDIV_DIV_EN
        S_DIV: begin
          acc_hi <= div_hi_nx;
          acc_lo <= div_lo_nx;
          cnt    <= cnt + 1'b1;
        end
`endif
        S_FIX: begin
`ifdef ALU_MULDIV_DIV_EN
          if (op_div) begin
            hi <= neg_r ? -acc_hi : acc_hi;
            lo <= neg_q ? -acc_lo : acc_lo;
          end else
`endif
          begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// MIPS-style ALU with a multi-cycle multiply/divide engine and HI/LO
// registers. Optional divider: define ALU_MULDIV_DIV_EN to build it.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       control,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alu_muldiv_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (A),
    .b       (B),
    .control (control),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .div0    (div0),
    .hi      (hi),
    .lo      (lo)
  );

  // Single-cycle ALU and result mux; MFHI/MFLO read HI/LO with no interlock
  always_comb begin
    result = '0;
    case (control)
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_ADD:  result = A + B;
      OP_SUB:  result = A - B;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, A < B};
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (WIDTH=32). Divide vectors
// follow the ALU_MULDIV_DIV_EN setting of the build.
module tb_alu_muldiv;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  A = '0, B = '0;
  logic [3:0]    control = 4'b0000;
  logic          start = 1'b0;
  logic [W-1:0]  result, hi, lo;
  logic          zero, busy, done, div0;

  int n_tests = 0;
  int n_fail  = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .control (control),
    .start   (start),
    .result  (result),
    .zero    (zero),
    .busy    (busy),
    .done    (done),
    .div0    (div0),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Combinational vector: apply, settle, compare result
  task automatic alu_vec(input string tag, input logic [3:0] c,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp);
    control = c; A = a; B = b;
    #1;
    check(tag, {32'd0, result}, {32'd0, exp});
  endtask

  // Launch a multi-cycle op from the current cycle (caller sits between a
  // negedge and the next posedge). Returns the number of rising edges from
  // acceptance to the edge at which done is first sampled high, or -1.
  // Returns at the negedge inside the done cycle.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat);
    int n;
    control = c; A = a; B = b; start = 1'b1;
    @(posedge clk);
    n = 0;
    lat = -1;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = n + 1;
        break;
      end
      if (n >= 200) break;
      @(posedge clk);
      n++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [W-1:0] prev_hi, prev_lo;

    // Reset state
    #2;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_div0", {63'd0, div0}, 64'd0);
    check("rst_hi",   {32'd0, hi},   64'd0);
    check("rst_lo",   {32'd0, lo},   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-cycle operations, A=0xA B=0x7
    alu_vec("and",  4'b0000, 32'hA, 32'h7, 32'h2);
    alu_vec("or",   4'b0001, 32'hA, 32'h7, 32'hF);
    alu_vec("add",  4'b0010, 32'hA, 32'h7, 32'h11);
    alu_vec("sub",  4'b0110, 32'hA, 32'h7, 32'h3);
    alu_vec("slt",  4'b0111, 32'hA, 32'h7, 32'h0);
    alu_vec("xor",  4'b0011, 32'hA, 32'h7, 32'hD);
    alu_vec("nor",  4'b0100, 32'hA, 32'h7, 32'hFFFF_FFF0);
    alu_vec("sltu", 4'b0101, 32'hA, 32'h7, 32'h0);
    alu_vec("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1);
    alu_vec("sltu_neg", 4'b0101, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_vec("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0);
    check("add_wrap_zero", {63'd0, zero}, 64'd1);
    alu_vec("sub_wrap", 4'b0110, 32'h0, 32'h1, 32'hFFFF_FFFF);
    alu_vec("sub_eq", 4'b0110, 32'h1234, 32'h1234, 32'h0);
    check("sub_eq_zero", {63'd0, zero}, 64'd1);
    alu_vec("sub_nz_zero_flag", 4'b0110, 32'h5, 32'h4, 32'h1);
    check("sub_nz_zero", {63'd0, zero}, 64'd0);
    alu_vec("undef_code", 4'b1110, 32'hA, 32'h7, 32'h0);
    alu_vec("mfhi_rst", 4'b1100, 32'hA, 32'h7, 32'h0);

    // MULT -3 * 5 = -15
    run_op(4'b1000, 32'hFFFF_FFFD, 32'd5, lat);
    check("mult_lat", lat, 34);
    check("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'd0, lo}, 64'hFFFF_FFF1);
    check("mult_busy_done_cycle", {63'd0, busy}, 64'd0);
    // Back-to-back: MULTU issued in the done cycle
    run_op(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("multu_b2b_lat", lat, 34);
    check("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    check("multu_lo", {32'd0, lo}, 64'h1);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    alu_vec("mflo", 4'b1101, 32'h0, 32'h0, 32'h1);
    alu_vec("mfhi", 4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFE);

    // Start while busy is ignored; MFHI/MFLO during busy return old values
    prev_hi = 32'hFFFF_FFFE;
    prev_lo = 32'h1;
    @(negedge clk);
    control = 4'b1001; A = 32'd6; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    repeat (3) @(negedge clk);
    alu_vec("mfhi_busy", 4'b1100, 32'h0, 32'h0, prev_hi);
    alu_vec("mflo_busy", 4'b1101, 32'h0, 32'h0, prev_lo);
    control = 4'b1000; A = 32'd100; B = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("busy_start_pulses", pulses, 1);
    check("busy_start_hi", {32'd0, hi}, 64'd0);
    check("busy_start_lo", {32'd0, lo}, 64'd42);

`ifdef ALU_MULDIV_DIV_EN
    run_op(4'b1010, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_lat", lat, 34);
    check("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    check("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    check("div_div0", {63'd0, div0}, 64'd0);
    run_op(4'b1010, 32'd7, 32'hFFFF_FFFE, lat);
    check("div_negb_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    check("div_negb_hi", {32'd0, hi}, 64'd1);
    run_op(4'b1011, 32'd100, 32'd7, lat);
    check("divu_lo", {32'd0, lo}, 64'd14);
    check("divu_hi", {32'd0, hi}, 64'd2);
    run_op(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_min_lo", {32'd0, lo}, 64'h8000_0000);
    check("div_min_hi", {32'd0, hi}, 64'd0);
    run_op(4'b1010, 32'd5, 32'd0, lat);
    check("div0_lat", lat, 2);
    check("div0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    check("div0_hi", {32'd0, hi}, 64'd5);
    check("div0_flag", {63'd0, div0}, 64'd1);
    run_op(4'b1001, 32'd3, 32'd4, lat);
    check("div0_clear", {63'd0, div0}, 64'd0);
    check("div0_clear_lo", {32'd0, lo}, 64'd12);
`else
    run_op(4'b1010, 32'd100, 32'd7, lat);
    check("nodiv_lat", lat, 1);
    check("nodiv_hi", {32'd0, hi}, 64'd0);
    check("nodiv_lo", {32'd0, lo}, 64'd42);
    check("nodiv_div0", {63'd0, div0}, 64'd0);
    run_op(4'b1011, 32'd5, 32'd0, lat);
    check("nodiv_divu_lat", lat, 1);
    check("nodiv_divu_lo", {32'd0, lo}, 64'd42);
    check("nodiv_div0_b0", {63'd0, div0}, 64'd0);
`endif

    // Reset at iteration 10 of a MULT aborts with no HI/LO update
    run_op(4'b1001, 32'd9, 32'd9, lat);
    check("pre_rst_lo", {32'd0, lo}, 64'd81);
    control = 4'b1000; A = 32'd1000; B = 32'd1000; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    check("abort_lo_after", {32'd0, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
